// File: rtl/iddmm_add_seq.sv
// Issue/drain sequencer for the IDDMM pipelined word adder.
// One N+1 iteration pass per start, aligned to 1-cycle RAMs and a 2-stage adder.
module iddmm_add_seq #(
   parameter int K      = 256,
   parameter int N      = 16,
   parameter int ADDR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              carry_i,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W:0]   j_cnt,
   output logic              carry_in,
   output logic              b_zero,
   output logic              wr_en,
   output logic [ADDR_W:0]   wr_addr
);

   localparam logic [ADDR_W:0] JLast = (ADDR_W + 1)'(N);
   localparam logic [ADDR_W:0] JOne  = (ADDR_W + 1)'(1);

   if (K < 1 || N < 1) begin : g_bad_cfg
   end

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } state_e;

   typedef struct packed {
      logic            v;
      logic [ADDR_W:0] j;
   } stage_t;

   state_e          state_q;
   logic [ADDR_W:0] j_q;
   logic            carry_q;
   stage_t          s1_q, s2_q, s3_q;
   stage_t          s1_d;
   logic            issue;
   logic            last_wr;

   assign issue   = (state_q == ISSUE);
   assign s1_d    = {issue, j_q};
   assign last_wr = s3_q.v && (s3_q.j == JLast);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         j_q     <= '0;
         carry_q <= 1'b0;
         s1_q    <= '0;
         s2_q    <= '0;
         s3_q    <= '0;
      end else begin
         // valid/index pipe mirrors RAM latency plus both adder registers
         s1_q <= s1_d;
         s2_q <= s1_q;
         s3_q <= s2_q;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= ISSUE;
                  j_q     <= '0;
                  carry_q <= carry_i;
               end
            end
            ISSUE: begin
               if (j_q == JLast) state_q <= DRAIN;
               else              j_q     <= j_q + JOne;
            end
            DRAIN: begin
               if (last_wr) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = (state_q != IDLE);
   assign rd_en    = issue && (j_q != JLast);
   assign rd_addr  = rd_en ? j_q[ADDR_W-1:0] : '0;
   assign j_cnt    = s1_q.v ? s1_q.j : '0;
   assign b_zero   = s1_q.v && (s1_q.j == JLast);
   assign carry_in = carry_q;
   assign wr_en    = s3_q.v;
   assign wr_addr  = s3_q.v ? s3_q.j : '0;
   assign done     = last_wr;

endmodule

// File: tb/tb_iddmm_add_seq.sv
// Scoreboard bench for iddmm_add_seq: three sizes share one random stimulus
// stream, each with a pass-timing model and a word-sum datapath check.
module tb_iddmm_add_seq;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic carry_i;
   logic chk_en = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   typedef struct {
      int         j;
      logic [7:0] d;
   } exp_t;

   for (genvar g = 0; g < 3; g++) begin : inst
      localparam int NN = (g == 0) ? 16 : ((g == 1) ? 5 : 1);
      localparam int AW = (NN > 1) ? $clog2(NN) : 1;

      logic          busy, done, rd_en, carry_in, b_zero, wr_en;
      logic [AW-1:0] rd_addr;
      logic [AW:0]   j_cnt, wr_addr;

      iddmm_add_seq #(.K(8), .N(NN)) dut (
         .clk(clk), .rst_n(rst_n), .start(start), .carry_i(carry_i),
         .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
         .j_cnt(j_cnt), .carry_in(carry_in), .b_zero(b_zero),
         .wr_en(wr_en), .wr_addr(wr_addr)
      );

      logic [7:0] mem_a [NN];
      logic [7:0] mem_b [NN];
      logic [7:0] ra_q, rb_q, add1_q, add2_q;

      initial begin
         for (int i = 0; i < NN; i++) begin
            mem_a[i] = 8'($urandom);
            mem_b[i] = 8'($urandom);
         end
      end

      // operand RAMs (1-cycle read) and a 2-register word adder
      always @(posedge clk) begin
         if (rd_en) begin
            ra_q <= mem_a[rd_addr];
            rb_q <= mem_b[rd_addr];
         end
         add1_q <= b_zero ? {7'd0, carry_in} : ra_q + rb_q;
         add2_q <= add1_q;
      end

      // k = cycle index within the current pass (acceptance = 0), -1 when idle
      int   k  = -1;
      logic pc = 1'b0;
      exp_t q[$];

      always @(posedge clk) begin
         if (!rst_n) begin
            k  = -1;
            pc = 1'b0;
            q.delete();
         end else if (k < 0) begin
            if (start) begin
               k  = 1;
               pc = carry_i;
               for (int j = 0; j <= NN; j++) begin
                  exp_t e;
                  e.j = j;
                  e.d = (j < NN) ? 8'(mem_a[j] + mem_b[j]) : {7'd0, carry_i};
                  q.push_back(e);
               end
            end
         end else begin
            k = (k == NN + 4) ? -1 : k + 1;
         end
      end

      always @(negedge clk) begin
         if (chk_en) begin
            logic       e_busy, e_rd, e_bz;
            int         e_ra, e_jc;
            logic [31:0] got, want;
            e_busy = (k >= 1) && (k <= NN + 4);
            e_rd   = (k >= 1) && (k <= NN);
            e_ra   = e_rd ? k - 1 : 0;
            e_jc   = (k >= 2 && k <= NN + 2) ? k - 2 : 0;
            e_bz   = (k == NN + 2);
            got  = {busy, rd_en, b_zero, carry_in, 12'd0, 8'(rd_addr), 8'(j_cnt)};
            want = {e_busy, e_rd, e_bz, pc, 12'd0, 8'(e_ra), 8'(e_jc)};
            n_chk++;
            if (got !== want) begin
               n_fail++;
               $display("FAIL ctrl N=%0d k=%0d got %h want %h", NN, k, got, want);
            end
            if (wr_en) begin
               n_chk++;
               if (q.size() == 0) begin
                  n_fail++;
                  $display("FAIL spurious_wr N=%0d k=%0d got wr_addr %0d want none",
                           NN, k, wr_addr);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  if (int'(wr_addr) != e.j || k != e.j + 4 ||
                      done !== (e.j == NN) || add2_q !== e.d) begin
                     n_fail++;
                     $display("FAIL wr N=%0d got addr %0d k %0d done %b data %h want addr %0d k %0d done %b data %h",
                              NN, wr_addr, k, done, add2_q,
                              e.j, e.j + 4, (e.j == NN), e.d);
                  end
               end
            end else begin
               if (done) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL done_no_wr N=%0d k=%0d got 1 want 0", NN, k);
               end
               if (q.size() > 0 && (k < 0 || k >= q[0].j + 4)) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL missing_wr N=%0d k=%0d got none want addr %0d",
                           NN, k, q[0].j);
                  q.delete();
               end
            end
         end
      end
   end

   task automatic step(input logic st, input logic cy, input logic rs, input int n);
      start   = st;
      carry_i = cy;
      rst_n   = rs;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      carry_i = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      step(0, 0, 0, 2);
      // single pass with carry
      step(1, 1, 1, 1);
      step(0, 0, 1, 25);
      // start held high: back-to-back passes, no overlap
      step(1, 0, 1, 60);
      step(0, 0, 1, 25);
      // abort mid-pass, then restart
      step(1, 1, 1, 1);
      step(0, 0, 1, 5);
      step(0, 0, 0, 1);
      step(0, 0, 1, 3);
      step(1, 1, 1, 1);
      step(0, 0, 1, 25);
      // random traffic including stray starts and resets
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(0, 3) == 0, 1'($urandom),
              $urandom_range(0, 149) != 0, 1);
      end
      step(0, 0, 1, 30);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
